gate_array_pipe: RTL and testbench

//   Parametrised successor to the fixed 16-bit AND gate vector: WIDTH-bit bitwise logic array, 8 selectable ops.

---
 rtl/gate_array_pipe_if.sv | 27 ++
 rtl/gate_array_pipe.sv | 114 +++++++++++
 tb/tb_gate_array_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_array_pipe_if.sv
// Handshake bundle for gate_array_pipe: operand producer side (in_*, op, a, b)
// and result consumer side (out_*, done_cnt).
interface gate_array_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [2:0]       out_op;
    logic [CNT_W-1:0] done_cnt;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, out_op, done_cnt
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, out_op, done_cnt
    );
endinterface

// File: rtl/gate_array_pipe.sv
// WIDTH-bit bitwise logic array (8 ops) whose result travels through a
// STAGES-deep bubble-collapsing valid/ready pipeline with full backpressure.
module gate_array_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_array_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_BUF_A = 3'd6,
        OP_NOT_A = 3'd7
    } op_e;

    logic [WIDTH-1:0]  result;
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [2:0]        op_q   [STAGES];
    logic [2:0]        op_d   [STAGES];
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic              in_ready;
    logic              accept;
    logic              out_fire;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        result = '0;
        case (op_e'(bus.op))
            OP_AND:   result = bus.a & bus.b;
            OP_OR:    result = bus.a | bus.b;
            OP_XOR:   result = bus.a ^ bus.b;
            OP_NAND:  result = ~(bus.a & bus.b);
            OP_NOR:   result = ~(bus.a | bus.b);
            OP_XNOR:  result = ~(bus.a ^ bus.b);
            OP_BUF_A: result = bus.a;
            OP_NOT_A: result = ~bus.a;
        endcase
    end

    // Walk tail to head: a slot can take data if it is empty or its occupant moves on this cycle.
    always_comb begin : ready_chain
        logic ok;
        // NOTE: combinational blocks use blocking '=' so each line sees the value computed just above.
        ok  = bus.out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = v_q[k] && ok;
            ok     = !v_q[k] || ok;
        end
        in_ready = ok;
    end

    assign accept   = bus.in_valid && in_ready;
    assign out_fire = v_q[STAGES-1] && bus.out_ready;

    always_comb begin
        v_d        = v_q;
        data_d     = data_q;
        op_d       = op_q;
        done_cnt_d = done_cnt_q + (out_fire ? CNT_W'(1) : CNT_W'(0));

        if (accept) begin
            v_d[0]    = 1'b1;
            data_d[0] = result;
            op_d[0]   = bus.op;
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                v_d[k]    = 1'b1;
                data_d[k] = data_q[k-1];
                op_d[k]   = op_q[k-1];
            end else if (adv[k]) begin
                v_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            done_cnt_q <= '0;
            // NOTE: stage storage is reset too, because the tail slot drives out/out_op, which must read 0 after reset.
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
            v_q        <= v_d;
            data_q     <= data_d;
            op_q       <= op_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out       = data_q[STAGES-1];
    assign bus.out_op    = op_q[STAGES-1];
    assign bus.done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_gate_array_pipe.sv
// Self-checking bench for gate_array_pipe: three instances (16/2/16, 64/8/4, 1/1/4)
// share stimulus; each has its own scoreboard fed by a bitwise reference model.
module tb_gate_array_pipe;
    localparam int W_M = 16, S_M = 2, C_M = 16;
    localparam int W_W = 64, S_W = 8, C_W = 4;
    localparam int W_N = 1,  S_N = 1, C_N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gate_array_pipe_if #(.WIDTH(W_M), .CNT_W(C_M)) bus_m ();
    gate_array_pipe_if #(.WIDTH(W_W), .CNT_W(C_W)) bus_w ();
    gate_array_pipe_if #(.WIDTH(W_N), .CNT_W(C_N)) bus_n ();

    gate_array_pipe #(.WIDTH(W_M), .STAGES(S_M), .CNT_W(C_M)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    gate_array_pipe #(.WIDTH(W_W), .STAGES(S_W), .CNT_W(C_W)) u_wide (.clk(clk), .rst_n(rst_n), .bus(bus_w));
    gate_array_pipe #(.WIDTH(W_N), .STAGES(S_N), .CNT_W(C_N)) u_bit  (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: the op table applied to full 64-bit words, then cut to the instance width.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input int w);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (o)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = x;
            default: r = ~x;
        endcase
        return r & mask;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [2:0]  op;
    } exp_t;

    exp_t q_m[$], q_w[$], q_n[$];
    exp_t e_m, e_w, e_n;
    int   xf_m = 0, xf_w = 0, xf_n = 0;

    // Handshakes are sampled mid-cycle; the transfer they describe happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_m.in_valid && bus_m.in_ready)
                q_m.push_back('{ref_op(bus_m.op, 64'(bus_m.a), 64'(bus_m.b), W_M), bus_m.op});
            if (bus_m.out_valid && bus_m.out_ready) begin
                xf_m++;
                if (q_m.size() == 0) check("main_unexpected_out", 64'(q_m.size()), 64'd1);
                else begin
                    e_m = q_m.pop_front();
                    check("main_sb_data", 64'(bus_m.out), e_m.data);
                    check("main_sb_op", 64'(bus_m.out_op), 64'(e_m.op));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_w.in_valid && bus_w.in_ready)
                q_w.push_back('{ref_op(bus_w.op, bus_w.a, bus_w.b, W_W), bus_w.op});
            if (bus_w.out_valid && bus_w.out_ready) begin
                xf_w++;
                if (q_w.size() == 0) check("wide_unexpected_out", 64'(q_w.size()), 64'd1);
                else begin
                    e_w = q_w.pop_front();
                    check("wide_sb_data", bus_w.out, e_w.data);
                    check("wide_sb_op", 64'(bus_w.out_op), 64'(e_w.op));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_n.in_valid && bus_n.in_ready)
                q_n.push_back('{ref_op(bus_n.op, 64'(bus_n.a), 64'(bus_n.b), W_N), bus_n.op});
            if (bus_n.out_valid && bus_n.out_ready) begin
                xf_n++;
                if (q_n.size() == 0) check("bit_unexpected_out", 64'(q_n.size()), 64'd1);
                else begin
                    e_n = q_n.pop_front();
                    check("bit_sb_data", 64'(bus_n.out), e_n.data);
                    check("bit_sb_op", 64'(bus_n.out_op), 64'(e_n.op));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input logic ordy);
        bus_m.in_valid = v;  bus_w.in_valid = v;  bus_n.in_valid = v;
        bus_m.op = o;        bus_w.op = o;        bus_n.op = o;
        bus_m.a = x[15:0];   bus_w.a = x;         bus_n.a = x[0:0];
        bus_m.b = y[15:0];   bus_w.b = y;         bus_n.b = y[0:0];
        bus_m.out_ready = ordy; bus_w.out_ready = ordy; bus_n.out_ready = ordy;
    endtask

    task automatic tick(output logic acc);
        @(negedge clk);
        acc = bus_m.in_valid && bus_m.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q_m.delete(); q_w.delete(); q_n.delete();
        xf_m = 0; xf_w = 0; xf_n = 0;
        #1;
        check("rst_out_valid", 64'(bus_m.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus_m.in_ready), 64'd1);
        check("rst_out", 64'(bus_m.out), 64'd0);
        check("rst_out_op", 64'(bus_m.out_op), 64'd0);
        check("rst_done_cnt", 64'(bus_m.done_cnt), 64'd0);
        check("rst_wide_out_valid", 64'(bus_w.out_valid), 64'd0);
        check("rst_wide_done_cnt", 64'(bus_w.done_cnt), 64'd0);
        check("rst_bit_out_valid", 64'(bus_n.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer with out_ready high; checks per-instance latency, result and op.
    task automatic send_one(input string tag, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
        logic        acc;
        int          lm, lw, ln;
        logic [63:0] om, ow, on;
        logic [2:0]  pm, pw, pn;
        acc = 1'b0;
        lm = 0; lw = 0; ln = 0;
        om = '0; ow = '0; on = '0; pm = '0; pw = '0; pn = '0;
        drive(1'b1, o, {4{x}}, {4{y}}, 1'b1);
        for (int c = 0; c < 20 && !acc; c++) tick(acc);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        drive(1'b0, o, {4{x}}, {4{y}}, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (lm == 0 && bus_m.out_valid === 1'b1) begin lm = c; om = 64'(bus_m.out); pm = bus_m.out_op; end
            if (lw == 0 && bus_w.out_valid === 1'b1) begin lw = c; ow = bus_w.out;      pw = bus_w.out_op; end
            if (ln == 0 && bus_n.out_valid === 1'b1) begin ln = c; on = 64'(bus_n.out); pn = bus_n.out_op; end
            if (lm != 0 && lw != 0 && ln != 0) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_lat_main"}, 64'(lm), 64'(S_M));
        check({tag, "_lat_wide"}, 64'(lw), 64'(S_W));
        check({tag, "_lat_bit"},  64'(ln), 64'(S_N));
        check({tag, "_out_main"}, om, 64'(e));
        check({tag, "_out_wide"}, ow, {4{e}});
        check({tag, "_out_bit"},  on, 64'(e[0]));
        check({tag, "_op_main"},  64'(pm), 64'(o));
        check({tag, "_op_wide"},  64'(pw), 64'(o));
        check({tag, "_op_bit"},   64'(pn), 64'(o));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_main_left"}, 64'(q_m.size()), 64'd0);
        check({tag, "_wide_left"}, 64'(q_w.size()), 64'd0);
        check({tag, "_bit_left"},  64'(q_n.size()), 64'd0);
        check({tag, "_main_done"}, 64'(bus_m.done_cnt), 64'(xf_m % (1 << C_M)));
        check({tag, "_wide_done"}, 64'(bus_w.done_cnt), 64'(xf_w % (1 << C_W)));
        check({tag, "_bit_done"},  64'(bus_n.done_cnt), 64'(xf_n % (1 << C_N)));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        logic        v, r;
        logic [63:0] x, y;
        logic [15:0] hold;
        int          acc_cnt;
        int          cyc;

        vecs[0] = '{3'd0, 16'hf0f0, 16'hff00, 16'hf000};
        vecs[1] = '{3'd1, 16'hf0f0, 16'hff00, 16'hfff0};
        vecs[2] = '{3'd2, 16'hf0f0, 16'hff00, 16'h0ff0};
        vecs[3] = '{3'd3, 16'hf0f0, 16'hff00, 16'h0fff};
        vecs[4] = '{3'd4, 16'hf0f0, 16'hff00, 16'h000f};
        vecs[5] = '{3'd5, 16'hf0f0, 16'hff00, 16'hf00f};
        vecs[6] = '{3'd6, 16'hf0f0, 16'hff00, 16'hf0f0};
        vecs[7] = '{3'd7, 16'hf0f0, 16'hff00, 16'h0f0f};

        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        do_reset();

        // AND walk: a grows 0001..7fff while b shrinks ffff>>n.
        for (int n = 0; n < 15; n++) begin
            logic [15:0] wa, wb;
            wa = (16'd1 << (n + 1)) - 16'd1;
            wb = 16'hffff >> n;
            send_one("walk", 3'd0, wa, wb, wa & wb);
        end

        for (int i = 0; i < 8; i++) send_one("ops", vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure: consumer stalls for 10 cycles while the producer keeps offering.
        acc_cnt = 0;
        hold = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            tick(acc);
            acc_cnt += int'(acc);
            if (i == 3) hold = bus_m.out;
        end
        check("bp_accepts", 64'(acc_cnt), 64'(S_M));
        check("bp_in_ready", 64'(bus_m.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus_m.out_valid), 64'd1);
        check("bp_out_hold", 64'(bus_m.out), 64'(hold));
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        repeat (12) tick(acc);
        check_drained("bp");

        // Random traffic; operands are X whenever in_valid is low.
        do_reset();
        cyc = 0;
        while (xf_m < 2000 && cyc < 40000) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (!v) begin
                x = 'x;
                y = 'x;
            end
            drive(v, 3'($urandom_range(0, 7)), x, y, r);
            tick(acc);
            cyc++;
        end
        drive(1'b0, 3'd0, 'x, 'x, 1'b0);
        check("rand_xfers", 64'(xf_m), 64'd2000);
        check("rand_done_cnt", 64'(bus_m.done_cnt), 64'd2000);
        drive(1'b0, 3'd0, 'x, 'x, 1'b1);
        repeat (15) tick(acc);
        check_drained("rand");

        // Reset with two results in flight.
        drive(1'b1, 3'd2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        tick(acc);
        tick(acc);
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        check("mid_out_valid", 64'(bus_m.out_valid), 64'd1);
        check("mid_in_ready", 64'(bus_m.in_ready), 64'd0);
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        do_reset();
        check("post_rst_out_valid0", 64'(bus_m.out_valid), 64'd0);
        check("post_rst_done_cnt0", 64'(bus_m.done_cnt), 64'd0);
        tick(acc);
        check("post_rst_out_valid1", 64'(bus_m.out_valid), 64'd0);
        send_one("post_rst", vecs[5].op, vecs[5].a, vecs[5].b, vecs[5].exp);

        // 17 back-to-back transfers: 4-bit counters wrap to 1.
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'(i % 8), {4{16'hf0f0}}, {4{16'hff00}}, 1'b1);
            tick(acc);
            acc_cnt += int'(acc);
        end
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        repeat (12) tick(acc);
        check("sweep_accepts", 64'(acc_cnt), 64'd17);
        check("sweep_wide_done", 64'(bus_w.done_cnt), 64'd1);
        check("sweep_bit_done", 64'(bus_n.done_cnt), 64'd1);
        check("sweep_main_done", 64'(bus_m.done_cnt), 64'd17);
        check_drained("sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
